// File: rtl/uart_frame_parser_if.sv
// Bus bundle for uart_frame_parser.
// Groups the receive stream, the transmit handshake and the held-frame
// read-out port. The parser connects through the slave modport. The
// environment (UART core, consumer, testbench) uses the master modport.
//   rx_data/rx_valid    : received byte stream (1-cycle valid pulse)
//   tx_data/tx_start    : response byte and 1-cycle launch pulse
//   tx_busy             : transmitter busy
//   frame_valid/cmd/len : held good frame
//   pay_addr/pay_data   : combinational payload read port
//   frame_ack           : consumer releases the held frame
//   frame_err           : 1-cycle error pulse
//   drop_cnt            : saturating count of bytes dropped while holding
interface uart_frame_parser_if #(
    parameter int MAX_LEN = 16
);
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int LW = $clog2(MAX_LEN + 1);

    logic [7:0]    rx_data;
    logic          rx_valid;
    logic [7:0]    tx_data;
    logic          tx_start;
    logic          tx_busy;
    logic          frame_valid;
    logic [7:0]    frame_cmd;
    logic [LW-1:0] frame_len;
    logic [AW-1:0] pay_addr;
    logic [7:0]    pay_data;
    logic          frame_ack;
    logic          frame_err;
    logic [7:0]    drop_cnt;

    modport slave (
        input  rx_data, rx_valid, tx_busy, pay_addr, frame_ack,
        output tx_data, tx_start, frame_valid, frame_cmd, frame_len,
               pay_data, frame_err, drop_cnt
    );

    modport master (
        output rx_data, rx_valid, tx_busy, pay_addr, frame_ack,
        input  tx_data, tx_start, frame_valid, frame_cmd, frame_len,
               pay_data, frame_err, drop_cnt
    );
endinterface

// File: rtl/uart_frame_parser.sv
// UART frame parser.
// Assembles SOF, CMD, LEN, PAYLOAD[LEN], CHK frames (CHK = XOR of CMD, LEN
// and payload) from the received byte stream, holds the payload of a good
// frame until the consumer acknowledges it, and answers each checked frame
// with a single ACK/NACK byte through the transmitter handshake.
// Ports:
//   clk   : system clock
//   reset : asynchronous reset, active-high
//   bus   : uart_frame_parser_if.slave (see interface for signal list)
module uart_frame_parser #(
    parameter int         MAX_LEN        = 16,
    parameter int         TIMEOUT_CYCLES = 12000,
    parameter logic [7:0] SOF_BYTE       = 8'hA5,
    parameter logic [7:0] ACK_BYTE       = 8'h06,
    parameter logic [7:0] NACK_BYTE      = 8'h15
) (
    input logic                clk,
    input logic                reset,
    uart_frame_parser_if.slave bus
);
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, CMD, LEN, PAY, CHK, HOLD} state_t;

    state_t        state_q, state_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [7:0]    chk_q, chk_d;
    logic [7:0]    drop_q, drop_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] idx_q, idx_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;
    logic          resp_full_q, resp_full_d;
    logic [7:0]    resp_q, resp_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_start_q, tx_start_d;
    logic [1:0]    blind_q, blind_d;

    logic          buf_we;
    logic          resp_new;
    logic [7:0]    resp_val;
    logic          launch;
    logic          timing;
    logic [7:0]    buf_q [MAX_LEN];

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        chk_d    = chk_q;
        len_d    = len_q;
        idx_d    = idx_q;
        drop_d   = drop_q;
        tmo_d    = tmo_q;
        err_d    = 1'b0;
        buf_we   = 1'b0;
        resp_new = 1'b0;
        resp_val = ACK_BYTE;

        case (state_q)
            IDLE: begin
                if (bus.rx_valid && bus.rx_data == SOF_BYTE) state_d = CMD;
            end
            CMD: begin
                if (bus.rx_valid) begin
                    cmd_d   = bus.rx_data;
                    chk_d   = bus.rx_data;
                    idx_d   = '0;
                    state_d = LEN;
                end
            end
            LEN: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data > 8'(MAX_LEN)) begin
                        err_d    = 1'b1;
                        resp_new = 1'b1;
                        resp_val = NACK_BYTE;
                        state_d  = IDLE;
                    end else begin
                        len_d   = bus.rx_data[LW-1:0];
                        chk_d   = chk_q ^ bus.rx_data;
                        state_d = (bus.rx_data == 8'd0) ? CHK : PAY;
                    end
                end
            end
            PAY: begin
                if (bus.rx_valid) begin
                    buf_we = 1'b1;
                    chk_d  = chk_q ^ bus.rx_data;
                    idx_d  = idx_q + LW'(1);
                    if (idx_q + LW'(1) == len_q) state_d = CHK;
                end
            end
            CHK: begin
                if (bus.rx_valid) begin
                    resp_new = 1'b1;
                    if (bus.rx_data == chk_q) begin
                        resp_val = ACK_BYTE;
                        state_d  = HOLD;
                    end else begin
                        resp_val = NACK_BYTE;
                        err_d    = 1'b1;
                        state_d  = IDLE;
                    end
                end
            end
            HOLD: begin
                // Bytes arriving while a frame is held are discarded and counted.
                if (bus.rx_valid && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
                if (bus.frame_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Inter-byte timeout: only inside a frame; a byte in the expiry
        // cycle takes priority and simply reloads the counter.
        timing = (state_q == CMD) || (state_q == LEN) || (state_q == PAY) || (state_q == CHK);
        if (bus.rx_valid || !timing) begin
            tmo_d = '0;
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            tmo_d   = '0;
            err_d   = 1'b1;
            state_d = IDLE;
        end else begin
            tmo_d = tmo_q + TW'(1);
        end

        // Single-entry response slot. The transmitter raises tx_busy only a
        // couple of cycles after tx_start, so busy is masked right after a launch.
        launch      = resp_full_q && (blind_q == 2'd0) && !bus.tx_busy;
        resp_full_d = resp_full_q;
        resp_d      = resp_q;
        if (launch) resp_full_d = 1'b0;
        if (resp_new) begin
            resp_full_d = 1'b1;
            resp_d      = resp_val;
        end
        tx_start_d = launch;
        tx_data_d  = launch ? resp_q : tx_data_q;
        blind_d    = launch ? 2'd2 : ((blind_q != 2'd0) ? blind_q - 2'd1 : 2'd0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            chk_q       <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            drop_q      <= '0;
            tmo_q       <= '0;
            err_q       <= 1'b0;
            resp_full_q <= 1'b0;
            resp_q      <= '0;
            tx_data_q   <= '0;
            tx_start_q  <= 1'b0;
            blind_q     <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            chk_q       <= chk_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            drop_q      <= drop_d;
            tmo_q       <= tmo_d;
            err_q       <= err_d;
            resp_full_q <= resp_full_d;
            resp_q      <= resp_d;
            tx_data_q   <= tx_data_d;
            tx_start_q  <= tx_start_d;
            blind_q     <= blind_d;
        end
    end

    always_ff @(posedge clk) begin
        if (buf_we) buf_q[idx_q[AW-1:0]] <= bus.rx_data;
    end

    assign bus.frame_valid = (state_q == HOLD);
    assign bus.frame_cmd   = cmd_q;
    assign bus.frame_len   = len_q;
    assign bus.pay_data    = (int'(bus.pay_addr) < MAX_LEN) ? buf_q[bus.pay_addr] : 8'h00;
    assign bus.frame_err   = err_q;
    assign bus.drop_cnt    = drop_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.tx_start    = tx_start_q;
endmodule

// File: tb/tb_uart_frame_parser.sv
// Testbench for uart_frame_parser: randomized and directed frames, a
// list-based reference model, and a scoreboard monitor that checks every
// tx_start, frame_err and frame_valid rise against queued expectations.
module tb_uart_frame_parser;
    localparam int         MAX_LEN = 16;
    localparam int         TIMEOUT = 12000;
    localparam logic [7:0] SOF     = 8'hA5;
    localparam logic [7:0] ACK     = 8'h06;
    localparam logic [7:0] NACK    = 8'h15;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uart_frame_parser_if #(.MAX_LEN(MAX_LEN)) bus ();

    uart_frame_parser #(
        .MAX_LEN(MAX_LEN), .TIMEOUT_CYCLES(TIMEOUT),
        .SOF_BYTE(SOF), .ACK_BYTE(ACK), .NACK_BYTE(NACK)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    typedef struct {
        logic [7:0] cmd;
        int         len;
    } frm_t;

    int         checks = 0;
    int         passes = 0;
    logic [7:0] exp_tx[$];
    int         exp_err = 0;
    frm_t       exp_frm[$];

    // Reference model state: bytes of the frame being collected (after SOF).
    logic [7:0] part[$];
    bit         collecting = 0;
    bit         holding = 0;
    int         drop = 0;
    logic [7:0] held_cmd;
    int         held_len = 0;
    logic [7:0] held_pay[$];
    bit         force_busy = 0;
    bit         pend_vld = 0;
    logic [7:0] pend;
    logic [7:0] pl[$];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endfunction

    function automatic void emit(input logic [7:0] r);
        if (force_busy) begin
            pend_vld = 1;
            pend     = r;
        end else begin
            exp_tx.push_back(r);
        end
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        logic [7:0] x;
        frm_t f;
        if (holding) begin
            if (drop < 255) drop++;
            return;
        end
        if (!collecting) begin
            if (b == SOF) begin
                collecting = 1;
                part.delete();
            end
            return;
        end
        part.push_back(b);
        if (part.size() == 2 && int'(part[1]) > MAX_LEN) begin
            exp_err++;
            emit(NACK);
            collecting = 0;
            return;
        end
        if (part.size() >= 3 && part.size() == int'(part[1]) + 3) begin
            x = 8'h00;
            for (int i = 0; i < part.size() - 1; i++) x ^= part[i];
            if (x == b) begin
                holding  = 1;
                held_cmd = part[0];
                held_len = int'(part[1]);
                held_pay.delete();
                for (int i = 0; i < held_len; i++) held_pay.push_back(part[2 + i]);
                f.cmd = held_cmd;
                f.len = held_len;
                exp_frm.push_back(f);
                emit(ACK);
            end else begin
                exp_err++;
                emit(NACK);
            end
            collecting = 0;
        end
    endfunction

    // Scoreboard monitor.
    initial begin : monitor
        logic       fv_prev;
        logic [7:0] e;
        frm_t       f;
        fv_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.tx_start === 1'b1) begin
                if (exp_tx.size() == 0) begin
                    checks++;
                    $display("FAIL tx_unexpected: tx_start with tx_data=%02h, none expected", bus.tx_data);
                end else begin
                    e = exp_tx.pop_front();
                    check("tx_data", bus.tx_data, e);
                    if (e == ACK) check("ack_after_valid", bus.frame_valid, 1);
                end
            end
            if (bus.frame_err === 1'b1) begin
                checks++;
                if (exp_err == 0) $display("FAIL err_unexpected: frame_err=1, expected 0");
                else begin
                    exp_err--;
                    passes++;
                end
            end
            if (bus.frame_valid === 1'b1 && fv_prev === 1'b0) begin
                if (exp_frm.size() == 0) begin
                    checks++;
                    $display("FAIL valid_unexpected: frame_valid rose, expected no frame");
                end else begin
                    f = exp_frm.pop_front();
                    check("frame_cmd", bus.frame_cmd, f.cmd);
                    check("frame_len", bus.frame_len, f.len);
                end
            end
            fv_prev = bus.frame_valid;
        end
    end

    // Transmitter stand-in: busy for a few cycles after each launch.
    initial begin : txsim
        int cnt;
        cnt = 0;
        bus.tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.tx_start === 1'b1) cnt = 4;
            else if (cnt > 0) cnt--;
            bus.tx_busy = force_busy || (cnt > 0);
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        model_byte(b);
        @(negedge clk);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic fill_pl(input int n);
        pl.delete();
        for (int i = 0; i < n; i++) pl.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [7:0] len, input bit corrupt, input int gmax);
        logic [7:0] x;
        send_byte(SOF, $urandom_range(0, gmax));
        send_byte(cmd, $urandom_range(0, gmax));
        send_byte(len, $urandom_range(0, gmax));
        if (int'(len) > MAX_LEN) return;
        x = cmd ^ len;
        for (int i = 0; i < int'(len); i++) begin
            send_byte(pl[i], $urandom_range(0, gmax));
            x ^= pl[i];
        end
        if (corrupt) x ^= 8'($urandom_range(1, 255));
        send_byte(x, $urandom_range(0, gmax));
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_tx.size() != 0 || exp_err != 0 || exp_frm.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 300) $display("FAIL drain_%s: %0d responses, %0d errors, %0d frames still outstanding, expected 0",
                               tag, exp_tx.size(), exp_err, exp_frm.size());
        else passes++;
        repeat (6) @(negedge clk);
    endtask

    task automatic consume();
        check("hold_valid", bus.frame_valid, 1);
        for (int i = 0; i < held_len; i++) begin
            @(negedge clk);
            bus.pay_addr = i[3:0];
            #1;
            check("pay_data", bus.pay_data, held_pay[i]);
        end
        @(negedge clk);
        bus.frame_ack = 1'b1;
        holding = 0;
        @(negedge clk);
        bus.frame_ack = 1'b0;
        #1;
        check("release", bus.frame_valid, 0);
    endtask

    task automatic apply_reset(input string tag);
        reset = 1'b1;
        #1;
        check({tag, "_tx_data"}, bus.tx_data, 0);
        check({tag, "_tx_start"}, bus.tx_start, 0);
        check({tag, "_frame_valid"}, bus.frame_valid, 0);
        check({tag, "_frame_cmd"}, bus.frame_cmd, 0);
        check({tag, "_frame_len"}, bus.frame_len, 0);
        check({tag, "_frame_err"}, bus.frame_err, 0);
        check({tag, "_drop_cnt"}, bus.drop_cnt, 0);
        collecting = 0;
        holding    = 0;
        drop       = 0;
        pend_vld   = 0;
        part.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin : stim
        int kind;
        reset         = 1'b0;
        bus.rx_data   = 8'h00;
        bus.rx_valid  = 1'b0;
        bus.pay_addr  = '0;
        bus.frame_ack = 1'b0;
        #2;
        apply_reset("reset");
        repeat (2) @(negedge clk);

        // Basic good frame.
        pl.delete();
        pl.push_back(8'hAA);
        pl.push_back(8'h55);
        send_frame(8'h10, 8'd2, 0, 0);
        drain("t1");
        consume();

        // Zero-length good frame, then bad checksum.
        send_frame(8'h20, 8'd0, 0, 0);
        drain("t2a");
        consume();
        pl.delete();
        pl.push_back(8'h33);
        send_byte(SOF, 0); send_byte(8'h20, 0); send_byte(8'h01, 0);
        send_byte(8'h33, 0); send_byte(8'h00, 0);
        drain("t2b");

        // LEN too large, next byte parsed from IDLE.
        send_byte(SOF, 0); send_byte(8'h01, 0); send_byte(8'h11, 0);
        fill_pl(4);
        send_frame(8'h30, 8'd4, 0, 0);
        drain("t3");
        consume();

        // Inter-byte timeout.
        send_byte(SOF, 0);
        send_byte(8'h01, 0);
        repeat (TIMEOUT - 20) @(negedge clk);
        collecting = 0;
        exp_err++;
        drain("timeout");
        fill_pl(MAX_LEN);
        send_frame(8'h44, 8'(MAX_LEN), 0, 1);
        drain("after_timeout");

        // Bytes while holding are dropped and counted, saturating.
        for (int i = 0; i < 300; i++) send_byte(8'($urandom_range(0, 255)), 0);
        #1;
        check("drop_cnt_sat", bus.drop_cnt, drop);
        check("hold_cmd", bus.frame_cmd, held_cmd);
        check("hold_len", bus.frame_len, held_len);
        consume();
        fill_pl(1);
        send_frame(8'h55, 8'd1, 0, 0);
        drain("after_hold");
        consume();

        // Busy transmitter delays the response; a newer response replaces it.
        force_busy = 1;
        fill_pl(3);
        send_frame(8'h42, 8'd3, 0, 1);
        repeat (30) @(negedge clk);
        consume();
        send_frame(8'h43, 8'd40, 0, 1);
        repeat (10) @(negedge clk);
        if (pend_vld) exp_tx.push_back(pend);
        pend_vld   = 0;
        force_busy = 0;
        drain("busy_release");

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 9);
            if (kind == 8) send_byte(8'($urandom_range(0, 164)), $urandom_range(0, 3));
            if (kind == 7) begin
                send_frame(8'($urandom_range(0, 255)), 8'($urandom_range(MAX_LEN + 1, 255)), 0, 3);
            end else begin
                fill_pl(MAX_LEN);
                send_frame(8'($urandom_range(0, 255)),
                           (kind == 9) ? 8'd0 : 8'($urandom_range(0, MAX_LEN)),
                           (kind == 5 || kind == 6), 3);
            end
            drain("random");
            if (holding) consume();
        end

        // Reset in the middle of the payload: nothing held, no response.
        fill_pl(5);
        send_byte(SOF, 0); send_byte(8'h66, 0); send_byte(8'd5, 0);
        send_byte(pl[0], 0); send_byte(pl[1], 0);
        #2;
        apply_reset("rst_pay");
        repeat (20) @(negedge clk);
        fill_pl(2);
        send_frame(8'h77, 8'd2, 0, 1);
        drain("after_rst_pay");

        // Reset while holding.
        #2;
        apply_reset("rst_hold");
        repeat (20) @(negedge clk);
        drain("final");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
